// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
//   ROBSIZE / ROBINDEX : default entry count and rename-tag width
//   rob_type_e         : instruction class held by each entry
//   operand_t          : result of an operand lookup (ready flag + value)
package reorder_buffer_pkg;

    localparam int ROBSIZE  = 16;
    localparam int ROBINDEX = 4;

    typedef enum logic [1:0] {
        ROB_TYPE_NORMAL = 2'd0,
        ROB_TYPE_BRANCH = 2'd1,
        ROB_TYPE_STORE  = 2'd2,
        ROB_TYPE_JALR   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } operand_t;

endpackage

// File: rtl/reorder_buffer_operand_lookup.sv
// rob_operand_lookup: combinational operand read for the reservation stations.
//   q1_tag/q2_tag       : tags being looked up
//   ready/value         : stored per-entry result state
//   alu_fwd/lsb_fwd     : a CDB write that is actually being accepted this cycle
//   q*_ready/q*_value   : result availability; value reads 0 while not ready
module rob_operand_lookup
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = ROBSIZE,
    parameter int IDX_W    = ROBINDEX
) (
    input  logic [IDX_W-1:0]            q1_tag,
    input  logic [IDX_W-1:0]            q2_tag,
    input  logic [ROB_SIZE-1:0]         ready,
    input  logic [ROB_SIZE-1:0][31:0]   value,
    input  logic                        alu_fwd,
    input  logic [IDX_W-1:0]            alu_tag,
    input  logic [31:0]                 alu_value,
    input  logic                        lsb_fwd,
    input  logic [IDX_W-1:0]            lsb_tag,
    input  logic [31:0]                 lsb_value,
    output logic                        q1_ready,
    output logic                        q2_ready,
    output logic [31:0]                 q1_value,
    output logic [31:0]                 q2_value
);

    // ALU forward takes priority over LSB, which takes priority over stored
    // state; a result being written right now is newer than what the array holds.
    function automatic operand_t read_operand(
        input logic [IDX_W-1:0]          tag,
        input logic [ROB_SIZE-1:0]       rdy_vec,
        input logic [ROB_SIZE-1:0][31:0] val_vec,
        input logic                      a_fwd,
        input logic [IDX_W-1:0]          a_tag,
        input logic [31:0]               a_val,
        input logic                      l_fwd,
        input logic [IDX_W-1:0]          l_tag,
        input logic [31:0]               l_val
    );
        operand_t res;
        res.ready = 1'b0;
        res.value = 32'd0;
        if (a_fwd && (a_tag == tag)) begin
            res.ready = 1'b1;
            res.value = a_val;
        end else if (l_fwd && (l_tag == tag)) begin
            res.ready = 1'b1;
            res.value = l_val;
        end else if (rdy_vec[tag]) begin
            res.ready = 1'b1;
            res.value = val_vec[tag];
        end
        return res;
    endfunction

    operand_t op1;
    operand_t op2;

    always_comb begin
        op1 = read_operand(q1_tag, ready, value, alu_fwd, alu_tag, alu_value,
                           lsb_fwd, lsb_tag, lsb_value);
        op2 = read_operand(q2_tag, ready, value, alu_fwd, alu_tag, alu_value,
                           lsb_fwd, lsb_tag, lsb_value);
    end

    assign q1_ready = op1.ready;
    assign q1_value = op1.value;
    assign q2_ready = op2.ready;
    assign q2_value = op2.value;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the Tomasulo core.
//   Dispatch side : alloc_valid/type/rd/pc/pred in, alloc_tag (= tail) and rob_full out
//   Operand side  : q1_tag/q2_tag in, q*_ready/q*_value out (with CDB forward)
//   CDB side      : alu_valid/tag/value/taken/target and lsb_valid/tag/value in
//   Commit side   : commit_en/rd/tag/value, store_commit/store_tag, jump_wrong/jump_pc
//                   (all registered, one-cycle pulses)
//   rdy low freezes every piece of state, including the registered outputs.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = ROBSIZE,
    parameter int IDX_W    = ROBINDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [1:0]        alloc_type,
    input  logic [4:0]        alloc_rd,
    input  logic [31:0]       alloc_pc,
    input  logic              alloc_pred,
    output logic [IDX_W-1:0]  alloc_tag,
    output logic              rob_full,
    input  logic [IDX_W-1:0]  q1_tag,
    input  logic [IDX_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [31:0]       q1_value,
    output logic [31:0]       q2_value,
    input  logic              alu_valid,
    input  logic [IDX_W-1:0]  alu_tag,
    input  logic [31:0]       alu_value,
    input  logic              alu_taken,
    input  logic [31:0]       alu_target,
    input  logic              lsb_valid,
    input  logic [IDX_W-1:0]  lsb_tag,
    input  logic [31:0]       lsb_value,
    output logic              commit_en,
    output logic [4:0]        commit_rd,
    output logic [IDX_W-1:0]  commit_tag,
    output logic [31:0]       commit_value,
    output logic              store_commit,
    output logic [IDX_W-1:0]  store_tag,
    output logic              jump_wrong,
    output logic [31:0]       jump_pc
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_SIZE);

    // Pointers and occupancy
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    // Entry state: busy/ready are control and reset; payload is data and does not
    logic [ROB_SIZE-1:0]        busy;
    logic [ROB_SIZE-1:0]        ready;
    rob_type_e                  type_q   [ROB_SIZE];
    logic [4:0]                 rd_q     [ROB_SIZE];
    logic [31:0]                pc_q     [ROB_SIZE];
    logic                       pred_q   [ROB_SIZE];
    logic                       taken_q  [ROB_SIZE];
    logic [31:0]                target_q [ROB_SIZE];
    logic [ROB_SIZE-1:0][31:0]  value_q;

    logic flush;
    logic alloc_fire;
    logic alu_fire;
    logic lsb_fire;
    logic commit_fire;

    rob_type_e   head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_pc;
    logic        head_pred;
    logic        head_taken;
    logic [31:0] head_target;
    logic [31:0] head_value;

    assign alloc_tag = tail;
    assign rob_full  = (count == FULL_COUNT);

    // The cycle jump_wrong is high is the flush cycle: everything younger than
    // the mispredicted instruction is discarded, so no alloc, CDB or commit.
    assign flush       = jump_wrong;
    assign alloc_fire  = rdy && !flush && alloc_valid && !rob_full;
    assign alu_fire    = rdy && !flush && alu_valid && busy[alu_tag];
    assign lsb_fire    = rdy && !flush && lsb_valid && busy[lsb_tag];
    // Uses the registered ready bit, so a result written this cycle retires next cycle.
    assign commit_fire = rdy && !flush && busy[head] && ready[head];

    assign head_type   = type_q[head];
    assign head_rd     = rd_q[head];
    assign head_pc     = pc_q[head];
    assign head_pred   = pred_q[head];
    assign head_taken  = taken_q[head];
    assign head_target = target_q[head];
    assign head_value  = value_q[head];

    rob_operand_lookup #(
        .ROB_SIZE (ROB_SIZE),
        .IDX_W    (IDX_W)
    ) u_lookup (
        .q1_tag    (q1_tag),
        .q2_tag    (q2_tag),
        .ready     (ready),
        .value     (value_q),
        .alu_fwd   (alu_fire),
        .alu_tag   (alu_tag),
        .alu_value (alu_value),
        .lsb_fwd   (lsb_fire),
        .lsb_tag   (lsb_tag),
        .lsb_value (lsb_value),
        .q1_ready  (q1_ready),
        .q2_ready  (q2_ready),
        .q1_value  (q1_value),
        .q2_value  (q2_value)
    );

    // Control: pointers, entry flags and registered commit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            commit_en    <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= '0;
            commit_value <= '0;
            store_commit <= 1'b0;
            store_tag    <= '0;
            jump_wrong   <= 1'b0;
            jump_pc      <= '0;
        end else if (rdy) begin
            commit_en    <= 1'b0;
            store_commit <= 1'b0;
            jump_wrong   <= 1'b0;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (alu_fire) ready[alu_tag] <= 1'b1;
                if (lsb_fire) ready[lsb_tag] <= 1'b1;
                // Alloc only targets a free slot, so it never collides with the head
                if (alloc_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                    commit_tag  <= head;
                    case (head_type)
                        ROB_TYPE_NORMAL: begin
                            commit_en    <= 1'b1;
                            commit_rd    <= head_rd;
                            commit_value <= head_value;
                        end
                        ROB_TYPE_STORE: begin
                            store_commit <= 1'b1;
                            store_tag    <= head;
                        end
                        ROB_TYPE_BRANCH: begin
                            if (head_taken != head_pred) begin
                                jump_wrong <= 1'b1;
                                jump_pc    <= head_taken ? head_target : head_pc + 32'd4;
                            end
                        end
                        ROB_TYPE_JALR: begin
                            commit_en    <= 1'b1;
                            commit_rd    <= head_rd;
                            commit_value <= head_value;
                            jump_wrong   <= 1'b1;
                            jump_pc      <= head_target;
                        end
                        default: ;
                    endcase
                end
                count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
            end
        end
    end

    // Data: entry payload, written only on accepted alloc / CDB events
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            type_q[tail]  <= rob_type_e'(alloc_type);
            rd_q[tail]    <= alloc_rd;
            pc_q[tail]    <= alloc_pc;
            pred_q[tail]  <= alloc_pred;
            taken_q[tail] <= 1'b0;
        end
        if (alu_fire) begin
            value_q[alu_tag]  <= alu_value;
            taken_q[alu_tag]  <= alu_taken;
            target_q[alu_tag] <= alu_target;
        end
        if (lsb_fire) begin
            value_q[lsb_tag] <= lsb_value;
        end
    end

endmodule
